// File: rtl/gyro_frame_scheduler.sv
// Rate-controlled framer: snapshots gyro axes on each divider tick and streams
// SYNC,SYNC,seq,payload,CHK bytes over a valid/ready link. Option: GYRO_FRAME_TEMP_EN adds temperature bytes.
module gyro_frame_scheduler #(
  parameter int          CLK_HZ    = 100000000,
  parameter int          FRAME_HZ  = 100,
  parameter logic [7:0]  SYNC_BYTE = 8'h55
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_overrun,
  input  logic [15:0] x_axis_data,
  input  logic [15:0] y_axis_data,
  input  logic [15:0] z_axis_data,
  input  logic [15:0] temp_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  seq_num,
  output logic        overrun
);

  localparam int DIV = CLK_HZ / FRAME_HZ;
  localparam int CW  = $clog2(DIV);
`ifdef GYRO_FRAME_TEMP_EN
  localparam int NBYTES = 12;
`else
  localparam int NBYTES = 10;
`endif
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t        state_q;
  logic [CW-1:0] div_q;
  logic [15:0]   x_q, y_q, z_q;
  logic [7:0]    seq_q, chk_q, tx_data_q;
  logic [3:0]    idx_q;
  logic          tx_valid_q, busy_q, overrun_q;
  logic          tick_d;
  logic [7:0]    chk_d, next_byte_d;

`ifdef GYRO_FRAME_TEMP_EN
  logic [15:0]   t_q;
`else
  logic          temp_unused_d;
  assign temp_unused_d = ^temp_data;
`endif

  assign tick_d = (div_q == CW'(DIV - 1));

  // Checksum including the byte now on the bus, and the byte to present after it.
  always_comb begin
    chk_d       = chk_q;
    next_byte_d = 8'h00;
    if (idx_q >= 4'd2) begin
      chk_d = chk_q + tx_data_q;
    end else begin
      chk_d = chk_q;
    end
    case (idx_q)
      4'd0:    next_byte_d = SYNC_BYTE;
      4'd1:    next_byte_d = seq_q;
      4'd2:    next_byte_d = x_q[7:0];
      4'd3:    next_byte_d = x_q[15:8];
      4'd4:    next_byte_d = y_q[7:0];
      4'd5:    next_byte_d = y_q[15:8];
      4'd6:    next_byte_d = z_q[7:0];
`ifdef GYRO_FRAME_TEMP_EN
      4'd7:    next_byte_d = z_q[15:8];
      4'd8:    next_byte_d = t_q[7:0];
      4'd9:    next_byte_d = t_q[15:8];
      4'd10:   next_byte_d = chk_d;
`else
      4'd7:    next_byte_d = z_q[15:8];
      4'd8:    next_byte_d = chk_d;
`endif
      default: next_byte_d = 8'h00;
    endcase
  end

  // Divider, overrun flag and frame sequencing FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      x_q        <= 16'h0000;
      y_q        <= 16'h0000;
      z_q        <= 16'h0000;
`ifdef GYRO_FRAME_TEMP_EN
      t_q        <= 16'h0000;
`endif
      seq_q      <= 8'h00;
      chk_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      idx_q      <= 4'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      div_q <= tick_d ? '0 : div_q + 1'b1;

      // A dropped tick outranks a simultaneous clear.
      if (tick_d && (state_q == SEND)) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (tick_d && enable) begin
            x_q        <= x_axis_data;
            y_q        <= y_axis_data;
            z_q        <= z_axis_data;
`ifdef GYRO_FRAME_TEMP_EN
            t_q        <= temp_data;
`endif
            chk_q      <= 8'h00;
            idx_q      <= 4'd0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              seq_q      <= seq_q + 8'd1;
              state_q    <= IDLE;
            end else begin
              idx_q     <= idx_q + 4'd1;
              tx_data_q <= next_byte_d;
              chk_q     <= chk_d;
            end
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign seq_num  = seq_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_gyro_frame_scheduler.sv
// Randomized bench for gyro_frame_scheduler against a frame-queue reference model.
// Honours GYRO_FRAME_TEMP_EN when the bench is built with it.
module tb_gyro_frame_scheduler;

  localparam int DIV = 100;
`ifdef GYRO_FRAME_TEMP_EN
  localparam int NB = 12;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, clear_overrun, tx_ready;
  logic [15:0] x_axis_data, y_axis_data, z_axis_data, temp_data;
  logic        tx_valid, busy, overrun;
  logic [7:0]  tx_data, seq_num;

  gyro_frame_scheduler #(.CLK_HZ(1000), .FRAME_HZ(10), .SYNC_BYTE(8'h55)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_overrun(clear_overrun),
    .x_axis_data(x_axis_data), .y_axis_data(y_axis_data), .z_axis_data(z_axis_data),
    .temp_data(temp_data), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .busy(busy), .seq_num(seq_num), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: timer phase, queue of bytes still to send, sequence, overrun.
  int         m_cnt;
  bit         m_busy;
  logic [7:0] m_q [$];
  logic [7:0] m_seq;
  bit         m_ovr;

  bit         cap_en;
  logic [7:0] cap [$];
  int         busy_cycles;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_busy = 0;
    m_q.delete();
    m_seq  = 8'h00;
    m_ovr  = 0;
  endtask

  task automatic model_step(input bit en, input bit rdy, input bit clr,
                            input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z, input logic [15:0] t);
    bit tick;
    bit was_busy;
    int sum;
    tick     = (m_cnt == DIV - 1);
    was_busy = m_busy;
    m_cnt    = (m_cnt + 1) % DIV;
    if (tick && was_busy) m_ovr = 1;
    else if (clr)         m_ovr = 0;
    if (was_busy) begin
      if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_busy = 0;
          m_seq  = m_seq + 8'd1;
        end
      end
    end else if (tick && en) begin
      m_q.delete();
      m_q.push_back(8'h55);
      m_q.push_back(8'h55);
      m_q.push_back(m_seq);
      m_q.push_back(x[7:0]); m_q.push_back(x[15:8]);
      m_q.push_back(y[7:0]); m_q.push_back(y[15:8]);
      m_q.push_back(z[7:0]); m_q.push_back(z[15:8]);
`ifdef GYRO_FRAME_TEMP_EN
      m_q.push_back(t[7:0]); m_q.push_back(t[15:8]);
`endif
      sum = 0;
      for (int i = 2; i < m_q.size(); i++) sum += int'(m_q[i]);
      m_q.push_back(8'(sum % 256));
      m_busy = 1;
    end
  endtask

  // Called at a falling edge: compare, drive, advance model across next rising edge.
  task automatic step_cycle(input bit en, input bit rdy, input bit clr,
                            input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z, input logic [15:0] t);
    check_val("tx_valid", tx_valid, m_busy);
    check_val("busy", busy, m_busy);
    if (m_busy) check_val("tx_data", tx_data, m_q[0]);
    check_val("seq_num", seq_num, m_seq);
    check_val("overrun", overrun, m_ovr);
    if (busy) busy_cycles++;
    if (cap_en && tx_valid && rdy) cap.push_back(tx_data);
    enable = en; tx_ready = rdy; clear_overrun = clr;
    x_axis_data = x; y_axis_data = y; z_axis_data = z; temp_data = t;
    model_step(en, rdy, clr, x, y, z, t);
    @(negedge clk);
  endtask

  task automatic rand_cycle(input bit en, input bit rdy, input bit clr);
    step_cycle(en, rdy, clr, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  logic [7:0] exp1 [NB];
  bit         launched;
  bit         found;

  initial begin
`ifdef GYRO_FRAME_TEMP_EN
    exp1 = '{8'h55, 8'h55, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'h02, 8'h01, 8'hC2};
`else
    exp1 = '{8'h55, 8'h55, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hBF};
`endif
    reset = 1'b0; enable = 1'b0; clear_overrun = 1'b0; tx_ready = 1'b0;
    x_axis_data = 16'h0000; y_axis_data = 16'h0000; z_axis_data = 16'h0000; temp_data = 16'h0000;
    cap_en = 0; busy_cycles = 0;
    repeat (3) @(negedge clk);
    check_val("rst_tx_valid", tx_valid, 1'b0);
    check_val("rst_tx_data", tx_data, 8'h00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_seq", seq_num, 8'h00);
    check_val("rst_overrun", overrun, 1'b0);
    model_reset();
    reset = 1'b1;

    // Directed first frame; x changes once the frame is launched.
    cap_en = 1; launched = 0; busy_cycles = 0;
    for (int c = 0; c < 150; c++) begin
      if (tx_valid) launched = 1;
      step_cycle(1'b1, 1'b1, 1'b0, launched ? 16'hFFFF : 16'h1234,
                 16'hABCD, 16'h0001, 16'h0102);
    end
    cap_en = 0;
    check_val("frame1_len", cap.size(), NB);
    for (int i = 0; i < NB; i++)
      if (i < cap.size()) check_val($sformatf("frame1_b%0d", i), cap[i], exp1[i]);
    check_val("frame1_busy_cycles", busy_cycles, NB);
    check_val("frame1_seq_after", seq_num, 8'h01);

    // Sparse ready with inputs changing every cycle.
    for (int c = 0; c < 600; c++) rand_cycle(1'b1, $urandom_range(2) == 0, 1'b0);

    // Long stall: a tick lands while the frame is stuck.
    for (int c = 0; c < 250; c++) rand_cycle(1'b1, 1'b0, 1'b0);
    check_val("stall_overrun", overrun, 1'b1);
    check_val("stall_valid", tx_valid, 1'b1);
    rand_cycle(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) rand_cycle(1'b1, 1'b1, 1'b0);

    // Mixed enable, clear pulses and stall bursts.
    for (int c = 0; c < 3000; c++)
      rand_cycle($urandom_range(7) != 0,
                 ((c % 400) < 250) ? ($urandom_range(3) != 0) : 1'b0,
                 $urandom_range(15) == 0);

    // Enough frames to wrap the sequence number.
    for (int c = 0; c < 260 * DIV; c++) rand_cycle(1'b1, $urandom_range(7) != 0, 1'b0);

    // Reset while byte 5 is on the bus.
    found = 0;
    for (int c = 0; c < 3 * DIV && !found; c++) begin
      if (m_busy && m_q.size() == NB - 5) found = 1;
      else rand_cycle(1'b1, 1'b1, 1'b0);
    end
    check_val("reach_byte5", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_val("midrst_valid", tx_valid, 1'b0);
    check_val("midrst_seq", seq_num, 8'h00);
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_overrun", overrun, 1'b0);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    cap.delete(); cap_en = 1;
    for (int c = 0; c < 2 * DIV; c++) rand_cycle(1'b1, 1'b1, 1'b0);
    cap_en = 0;
    check_val("postrst_len_ok", cap.size() >= 3, 1'b1);
    if (cap.size() >= 3) begin
      check_val("postrst_b0", cap[0], 8'h55);
      check_val("postrst_b1", cap[1], 8'h55);
      check_val("postrst_b2", cap[2], 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
